dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: turns one CPU load/store into at most one word-wide
// memory transaction, handling byte lanes, alignment faults and the reply pulse.
module dmem_responder #(
   parameter logic [6:0] ALE_CODE = 7'b0000001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        op,
   input  logic [31:0] addr,
   input  logic [3:0]  write_type,
   input  logic [31:0] w_data_CPU,
   output logic        data_valid,
   output logic [31:0] r_data_CPU,
   output logic [6:0]  cache_exception,
   output logic [31:0] cache_badv,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]  state;
   logic        op_q;
   logic [31:0] addr_q;
   logic [3:0]  size_mask_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        exc_q;

   logic [3:0]  size_mask_in;
   logic        misaligned;
   logic [4:0]  lane_shift;
   logic [31:0] data_mask;

   // Unknown size encodings fall back to a full word access.
   always_comb begin
      case (write_type)
         4'b0001: size_mask_in = 4'b0001;
         4'b0011: size_mask_in = 4'b0011;
         default: size_mask_in = 4'b1111;
      endcase
      misaligned = ((size_mask_in == 4'b0011) && addr[0]) ||
                   ((size_mask_in == 4'b1111) && (addr[1:0] != 2'b00));
   end

   assign lane_shift = {addr_q[1:0], 3'b000};
   assign data_mask  = {{16{size_mask_q[3]}}, {8{size_mask_q[1]}}, 8'hFF};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= 1'b0;
         addr_q      <= 32'd0;
         size_mask_q <= 4'd0;
         wdata_q     <= 32'd0;
         rdata_q     <= 32'd0;
         exc_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  op_q        <= op;
                  addr_q      <= addr;
                  size_mask_q <= size_mask_in;
                  wdata_q     <= w_data_CPU;
                  rdata_q     <= 32'd0;
                  exc_q       <= misaligned;
                  state       <= misaligned ? RESP : ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) state <= WAIT;
            end
            WAIT: begin
               if (mem_rvalid) begin
                  rdata_q <= op_q ? 32'd0 : ((mem_rdata >> lane_shift) & data_mask);
                  state   <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Every output is gated by state so it reads zero outside its owning phase.
   always_comb begin
      data_valid      = 1'b0;
      r_data_CPU      = 32'd0;
      cache_exception = 7'd0;
      cache_badv      = 32'd0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = 32'd0;
      mem_wstrb       = 4'd0;
      mem_wdata       = 32'd0;
      if (state == RESP) begin
         data_valid = 1'b1;
         r_data_CPU = rdata_q;
         if (exc_q) begin
            cache_exception = ALE_CODE;
            cache_badv      = addr_q;
         end
      end
      if (state == ISSUE) begin
         mem_req   = 1'b1;
         mem_we    = op_q;
         mem_addr  = {addr_q[31:2], 2'b00};
         mem_wstrb = op_q ? (size_mask_q << addr_q[1:0]) : 4'b0000;
         mem_wdata = wdata_q << lane_shift;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level reference memory predicts
// CPU replies and bus transactions; separate monitors compare what the DUT shows.
module tb_dmem_responder;

   localparam logic [6:0] ALE = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        op = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [3:0]  write_type = 4'd0;
   logic [31:0] w_data_CPU = 32'd0;
   logic        data_valid;
   logic [31:0] r_data_CPU;
   logic [6:0]  cache_exception;
   logic [31:0] cache_badv;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] rdata;
      logic [6:0]  exc;
      logic [31:0] badv;
      int          lat;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          rdy_dly;
      int          rv_dly;
   } bus_t;

   resp_t respq[$];
   bus_t  busq[$];
   resp_t mon_r;

   logic [7:0]  ref_bytes [int unsigned];
   logic [31:0] ram [int unsigned];

   dmem_responder #(.ALE_CODE(ALE)) dut (
      .clk(clk), .rst(rst), .valid(valid), .op(op), .addr(addr),
      .write_type(write_type), .w_data_CPU(w_data_CPU),
      .data_valid(data_valid), .r_data_CPU(r_data_CPU),
      .cache_exception(cache_exception), .cache_badv(cache_badv),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Untouched memory holds a deterministic pattern so both models agree on it.
   function automatic logic [31:0] init_word(input logic [31:0] wa);
      return (wa * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      logic [31:0] w;
      if (ref_bytes.exists(a)) return ref_bytes[a];
      w = init_word({a[31:2], 2'b00});
      return w[8*a[1:0] +: 8];
   endfunction

   function automatic logic [31:0] bus_word(input logic [31:0] wa);
      if (ram.exists(wa)) return ram[wa];
      return init_word(wa);
   endfunction

   task automatic preload(input logic [31:0] wa, input logic [31:0] w);
      ram[wa] = w;
      for (int i = 0; i < 4; i++) ref_bytes[wa + 32'(i)] = w[8*i +: 8];
   endtask

   // Predicts the reply and any bus transaction, then presents the request and
   // holds it until the reply pulse shows up (returns at that negedge).
   task automatic applyStimulus(input logic o, input logic [31:0] a, input logic [3:0] wt,
                                input logic [31:0] wd, input int rdly, input int vdly);
      int n;
      int lane;
      bit mis;
      bit seen;
      resp_t r;
      bus_t b;
      logic [31:0] rd;
      n = (wt == 4'b0001) ? 1 : (wt == 4'b0011) ? 2 : 4;
      mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
      lane = int'(a[1:0]);
      r.rdata = 32'd0;
      r.exc = 7'd0;
      r.badv = 32'd0;
      if (mis) begin
         r.exc = ALE;
         r.badv = a;
         r.lat = 1;
      end else begin
         r.lat = 3 + rdly + vdly;
         b.addr = a & ~32'h3;
         b.we = o;
         b.rdy_dly = rdly;
         b.rv_dly = vdly;
         b.wstrb = o ? 4'(((1 << n) - 1) << lane) : 4'b0000;
         b.wdata = wd << (8 * lane);
         if (o) begin
            for (int i = 0; i < n; i++) ref_bytes[a + 32'(i)] = wd[8*i +: 8];
         end else begin
            rd = 32'd0;
            for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_byte(a + 32'(i));
            r.rdata = rd;
         end
         busq.push_back(b);
      end
      @(posedge clk);
      #1;
      valid = 1'b1;
      op = o;
      addr = a;
      write_type = wt;
      w_data_CPU = wd;
      r.cyc = cyc + r.lat;
      respq.push_back(r);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = data_valid;
      end
      checkOutput("handshake_timeout", {31'd0, seen}, 32'd1);
      if (!seen) begin
         respq.delete();
         busq.delete();
      end
   endtask

   task automatic idleCycles(input int n);
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (n - 1) @(posedge clk);
   endtask

   // CPU-side monitor: pops the scoreboard on each reply pulse and checks that
   // reply outputs stay quiet and the bus is idle while in reset.
   always @(negedge clk) begin
      if (data_valid) begin
         if (rst || respq.size() == 0) begin
            checkOutput("unexpected_data_valid", {31'd0, data_valid}, 32'd0);
         end else begin
            mon_r = respq.pop_front();
            checkOutput("r_data_CPU", r_data_CPU, mon_r.rdata);
            checkOutput("cache_exception", {25'd0, cache_exception}, {25'd0, mon_r.exc});
            checkOutput("cache_badv", cache_badv, mon_r.badv);
            checkOutput("reply_cycle", 32'(cyc), 32'(mon_r.cyc));
         end
      end else begin
         checkOutput("quiet_r_data", r_data_CPU, 32'd0);
         checkOutput("quiet_exception", {25'd0, cache_exception}, 32'd0);
         checkOutput("quiet_badv", cache_badv, 32'd0);
      end
      if (rst) checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
   end

   // Memory-side model: checks each transaction and its stability while stalled,
   // applies writes with strobes and returns read data after the chosen delays.
   initial begin : bus_model
      bus_t cur;
      bit active;
      bit pend;
      int rdy;
      int vd;
      logic [31:0] pend_data;
      logic [31:0] w;
      active = 1'b0;
      pend = 1'b0;
      rdy = 0;
      vd = 0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rvalid = 1'b0;
         if (pend) begin
            if (vd == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = pend_data;
               pend = 1'b0;
            end else vd--;
         end
         if (rst) active = 1'b0;
         else if (mem_req) begin
            if (!active) begin
               if (busq.size() == 0) checkOutput("spurious_mem_req", {31'd0, mem_req}, 32'd0);
               else begin
                  cur = busq.pop_front();
                  active = 1'b1;
                  rdy = cur.rdy_dly;
               end
            end
            if (active) begin
               checkOutput("mem_addr", mem_addr, cur.addr);
               checkOutput("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
               checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
               if (cur.we) checkOutput("mem_wdata", mem_wdata, cur.wdata);
               if (rdy == 0) begin
                  mem_ready = 1'b1;
                  active = 1'b0;
                  if (cur.we) begin
                     w = bus_word(cur.addr);
                     for (int i = 0; i < 4; i++)
                        if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                     ram[cur.addr] = w;
                     pend_data = $urandom;
                  end else begin
                     pend_data = bus_word(cur.addr);
                  end
                  pend = 1'b1;
                  vd = cur.rv_dly;
               end else rdy--;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   // Directed corner cases first, then a mid-transaction reset, then random traffic.
   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      preload(32'h1000, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'h1000, 4'b1111, 32'd0, 0, 0);
      applyStimulus(1'b1, 32'h1003, 4'b0001, 32'h000000AB, 0, 0);
      preload(32'h2000, 32'h12345678);
      applyStimulus(1'b0, 32'h2002, 4'b0011, 32'd0, 0, 0);
      applyStimulus(1'b0, 32'h3001, 4'b1111, 32'd0, 0, 0);
      applyStimulus(1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 5, 2);
      applyStimulus(1'b0, 32'h1001, 4'b0001, 32'd0, 1, 0);
      applyStimulus(1'b0, 32'h1002, 4'b0011, 32'd0, 0, 3);
      applyStimulus(1'b1, 32'h2001, 4'b0011, 32'h00005555, 0, 0);
      idleCycles(2);

      busq.push_back('{addr: 32'h5000, we: 1'b0, wstrb: 4'b0000, wdata: 32'd0, rdy_dly: 0, rv_dly: 6});
      @(posedge clk);
      #1;
      valid = 1'b1;
      op = 1'b0;
      addr = 32'h5000;
      write_type = 4'b1111;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      applyStimulus(1'b0, 32'h5000, 4'b1111, 32'd0, 1, 1);

      for (int t = 0; t < 150; t++) begin
         int sel;
         logic [3:0] wt;
         sel = $urandom_range(0, 3);
         wt = (sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0011 : (sel == 2) ? 4'b1111 : 4'($urandom);
         applyStimulus(1'($urandom_range(0, 1)), 32'h4000 + 32'($urandom_range(0, 63)), wt,
                       $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      end
      idleCycles(5);
      checkOutput("leftover_replies", 32'(respq.size()), 32'd0);
      checkOutput("leftover_bus", 32'(busq.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
